mvm_host_sequencer: RTL and testbench

//  Host-side initiator for the matrix-vector-multiply accelerator port.

---
 rtl/mvm_host_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mvm_host_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_host_sequencer.sv
// Host-side sequencer for the matrix-vector-multiply accelerator.
// Turns commands and an operand stream into the load/start strobes and bursts, then collects K results.
module mvm_host_sequencer #(
  parameter int K       = 32,
  parameter int B       = 8,
  parameter int RES_LAT = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  output logic           res_valid,
  output logic [2*B-1:0] res_data,
  output logic           res_last,
  output logic           busy,
  output logic           err_underflow,
  output logic           err_timeout,
  input  logic           err_clr,
  output logic           mvm_load_matrix,
  output logic           mvm_load_vector,
  output logic           mvm_start,
  output logic [B-1:0]   mvm_data_in,
  input  logic           mvm_done,
  input  logic [2*B-1:0] mvm_data_out
);

  localparam int EW = $clog2(K*K+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int CW = $clog2(RES_LAT+K+1);

  localparam logic [EW-1:0] MAT_END = EW'(K*K-1);
  localparam logic [EW-1:0] VEC_END = EW'(K-1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT-1);
  localparam logic [CW-1:0] COL_BEG = CW'(RES_LAT);
  localparam logic [CW-1:0] COL_END = CW'(RES_LAT+K-1);

  typedef enum logic [2:0] {
    IDLE,
    MAT_PULSE,
    MAT_STREAM,
    VEC_PULSE,
    VEC_STREAM,
    RUN_PULSE,
    WAIT_DONE,
    COLLECT
  } state_t;

  state_t        state;
  logic [EW-1:0] elem;
  logic [TW-1:0] tmo;
  logic [CW-1:0] ccnt;
  logic          run_after;

  logic stream;
  logic under_hit;
  logic tmo_hit;

  assign stream    = (state == MAT_STREAM) || (state == VEC_STREAM);
  assign under_hit = stream && !in_valid;
  assign tmo_hit   = (state == WAIT_DONE) && !mvm_done && (tmo == TMO_END);

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign in_ready    = stream;
  // Operand goes straight through so element e lands on cycle C+2+e.
  assign mvm_data_in = (stream && in_valid) ? in_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      elem            <= '0;
      tmo             <= '0;
      ccnt            <= '0;
      run_after       <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_last        <= 1'b0;
      err_underflow   <= 1'b0;
      err_timeout     <= 1'b0;
      mvm_load_matrix <= 1'b0;
      mvm_load_vector <= 1'b0;
      mvm_start       <= 1'b0;
    end else begin
      mvm_load_matrix <= 1'b0;
      mvm_load_vector <= 1'b0;
      mvm_start       <= 1'b0;
      res_valid       <= 1'b0;
      res_last        <= 1'b0;

      if (under_hit)    err_underflow <= 1'b1;
      else if (err_clr) err_underflow <= 1'b0;
      if (tmo_hit)      err_timeout   <= 1'b1;
      else if (err_clr) err_timeout   <= 1'b0;

      case (state)
        IDLE: begin
          elem <= '0;
          if (cmd_valid) begin
            unique case (cmd_op)
              2'd0: begin
                state           <= MAT_PULSE;
                mvm_load_matrix <= 1'b1;
              end
              2'd1, 2'd3: begin
                state           <= VEC_PULSE;
                mvm_load_vector <= 1'b1;
                run_after       <= cmd_op[1];
              end
              2'd2: begin
                state     <= RUN_PULSE;
                mvm_start <= 1'b1;
              end
            endcase
          end
        end
        MAT_PULSE: state <= MAT_STREAM;
        MAT_STREAM: begin
          if (elem == MAT_END) state <= IDLE;
          else                 elem  <= elem + 1'b1;
        end
        VEC_PULSE: state <= VEC_STREAM;
        VEC_STREAM: begin
          if (elem == VEC_END) begin
            if (run_after) begin
              state     <= RUN_PULSE;
              mvm_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            elem <= elem + 1'b1;
          end
        end
        RUN_PULSE: begin
          state <= WAIT_DONE;
          tmo   <= '0;
        end
        WAIT_DONE: begin
          if (mvm_done) begin
            state <= COLLECT;
            ccnt  <= CW'(1);
            // With zero latency y[0] is already on the bus in the done cycle.
            if (RES_LAT == 0) begin
              res_valid <= 1'b1;
              res_data  <= mvm_data_out;
            end
          end else if (tmo_hit) begin
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        COLLECT: begin
          ccnt <= ccnt + 1'b1;
          if (ccnt >= COL_BEG) begin
            res_valid <= 1'b1;
            res_data  <= mvm_data_out;
          end
          if (ccnt == COL_END) begin
            res_last <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_host_sequencer.sv
// Directed bench for mvm_host_sequencer (K=4, B=8, RES_LAT=1, TIMEOUT=20).
// Inputs change #1 after the rising edge; outputs are checked #1 later.
module tb_mvm_host_sequencer;

  localparam int K  = 4;
  localparam int B  = 8;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic           in_valid;
  logic           in_ready;
  logic [B-1:0]   in_data;
  logic           res_valid;
  logic [2*B-1:0] res_data;
  logic           res_last;
  logic           busy;
  logic           err_underflow;
  logic           err_timeout;
  logic           err_clr;
  logic           mvm_load_matrix;
  logic           mvm_load_vector;
  logic           mvm_start;
  logic [B-1:0]   mvm_data_in;
  logic           mvm_done;
  logic [2*B-1:0] mvm_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [B-1:0]   vec [K];
  logic [2*B-1:0] yexp [K];
  logic           saw_res;

  mvm_host_sequencer #(.K(K), .B(B), .RES_LAT(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .busy(busy), .err_underflow(err_underflow), .err_timeout(err_timeout),
    .err_clr(err_clr),
    .mvm_load_matrix(mvm_load_matrix), .mvm_load_vector(mvm_load_vector),
    .mvm_start(mvm_start), .mvm_data_in(mvm_data_in),
    .mvm_done(mvm_done), .mvm_data_out(mvm_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues a command in the current cycle; returns in cycle C+1 with cmd_valid low.
  task automatic issue(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    settle();
  endtask

  // Collects K results when mvm_done is raised in the current cycle D.
  task automatic collect(input string tag);
    mvm_done = 1'b1;
    tick();
    mvm_done = 1'b0;
    for (int i = 0; i <= K; i++) begin
      if (i < K) mvm_data_out = yexp[i];
      settle();
      if (i == 0) begin
        chk({tag, "_res_valid_d1"}, res_valid, 1'b0);
      end else begin
        chk({tag, "_res_valid"}, res_valid, 1'b1);
        chk({tag, "_res_data"}, res_data, yexp[i-1]);
        chk({tag, "_res_last"}, res_last, (i == K));
      end
      tick();
    end
    mvm_data_out = '0;
    settle();
    chk({tag, "_res_valid_end"}, res_valid, 1'b0);
    chk({tag, "_cmd_ready_end"}, cmd_ready, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    in_valid     = 1'b0;
    in_data      = '0;
    err_clr      = 1'b0;
    mvm_done     = 1'b0;
    mvm_data_out = '0;
    tick();
    tick();
    reset = 1'b0;
    settle();

    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_strobes", {mvm_load_matrix, mvm_load_vector, mvm_start}, 3'b000);
    chk("rst_errs", {err_underflow, err_timeout}, 2'b00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_data_in", mvm_data_in, 8'h00);

    // Identity matrix load; a command during the stream must be ignored.
    issue(2'd0);
    chk("id_load_matrix", mvm_load_matrix, 1'b1);
    chk("id_busy", busy, 1'b1);
    chk("id_cmd_ready_c1", cmd_ready, 1'b0);
    for (int e = 0; e < K*K; e++) begin
      tick();
      in_valid  = 1'b1;
      in_data   = (e % 5 == 0) ? 8'd1 : 8'd0;
      cmd_valid = (e == 3);
      cmd_op    = 2'd2;
      settle();
      chk("id_data_in", mvm_data_in, (e % 5 == 0) ? 8'd1 : 8'd0);
      chk("id_in_ready", in_ready, 1'b1);
      if (e == 0) chk("id_pulse_gone", mvm_load_matrix, 1'b0);
    end
    tick();
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    settle();
    chk("id_cmd_ready_c18", cmd_ready, 1'b1);
    chk("id_no_start", mvm_start, 1'b0);
    chk("id_no_underflow", err_underflow, 1'b0);
    chk("id_data_in_idle", mvm_data_in, 8'h00);

    // Load vector then run.
    vec[0] = 8'd3;  vec[1] = 8'hFE; vec[2] = 8'd5;  vec[3] = 8'd7;
    yexp[0] = 16'h0003; yexp[1] = 16'hFFFE;
    yexp[2] = 16'h0005; yexp[3] = 16'h0007;
    issue(2'd3);
    chk("v_load_vector", mvm_load_vector, 1'b1);
    for (int e = 0; e < K; e++) begin
      tick();
      in_valid = 1'b1;
      in_data  = vec[e];
      settle();
      chk("v_data_in", mvm_data_in, vec[e]);
    end
    tick();
    in_valid = 1'b0;
    settle();
    chk("v_start", mvm_start, 1'b1);
    chk("v_in_ready_off", in_ready, 1'b0);
    tick();
    chk("v_start_gone", mvm_start, 1'b0);
    chk("v_busy_wait", busy, 1'b1);
    tick();
    tick();
    collect("v");

    // Underflow on element 5, with err_clr colliding in the same cycle.
    issue(2'd0);
    for (int e = 0; e < K*K; e++) begin
      tick();
      in_valid = (e != 5);
      in_data  = 8'd2;
      err_clr  = (e == 5);
      settle();
      chk("u_data_in", mvm_data_in, (e == 5) ? 8'd0 : 8'd2);
      if (e == 5) chk("u_err_before", err_underflow, 1'b0);
      if (e == 6) chk("u_err_set", err_underflow, 1'b1);
      if (e == K*K-1) chk("u_busy_last", busy, 1'b1);
    end
    tick();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    settle();
    chk("u_cmd_ready", cmd_ready, 1'b1);
    chk("u_err_sticky", err_underflow, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    chk("u_err_cleared", err_underflow, 1'b0);

    // Run with no done: timeout.
    issue(2'd2);
    chk("t_start", mvm_start, 1'b1);
    saw_res = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (res_valid) saw_res = 1'b1;
    end
    chk("t_err_before", err_timeout, 1'b0);
    chk("t_busy_before", busy, 1'b1);
    tick();
    chk("t_err_set", err_timeout, 1'b1);
    chk("t_cmd_ready", cmd_ready, 1'b1);
    chk("t_no_res", {saw_res, res_valid}, 2'b00);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    chk("t_err_cleared", err_timeout, 1'b0);

    // Reset at element 8 of a matrix load.
    issue(2'd0);
    for (int e = 0; e <= 8; e++) begin
      tick();
      in_valid = 1'b1;
      in_data  = 8'h55;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("r_strobes", {mvm_load_matrix, mvm_load_vector, mvm_start}, 3'b000);
    chk("r_cmd_ready", cmd_ready, 1'b1);
    chk("r_busy", busy, 1'b0);
    chk("r_data_in", mvm_data_in, 8'h00);
    in_valid = 1'b0;

    // Extreme operands; results pass through at full 2B width.
    issue(2'd0);
    for (int e = 0; e < K*K; e++) begin
      tick();
      in_valid = 1'b1;
      in_data  = 8'h80;
      settle();
      chk("x_mat_data_in", mvm_data_in, 8'h80);
    end
    tick();
    in_valid = 1'b0;
    settle();
    yexp[0] = 16'h0000; yexp[1] = 16'h8000;
    yexp[2] = 16'h7FFF; yexp[3] = 16'hFFFF;
    issue(2'd3);
    for (int e = 0; e < K; e++) begin
      tick();
      in_valid = 1'b1;
      in_data  = 8'h80;
      settle();
      chk("x_vec_data_in", mvm_data_in, 8'h80);
    end
    tick();
    in_valid = 1'b0;
    tick();
    collect("x");
    chk("x_errs", {err_underflow, err_timeout}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
